// File: rtl/spi_seq_pkg.sv
// Shared constants and the one-hot FSM state type for the SPI burst sequencer.
package spi_seq_pkg;

  localparam int SPI_BYTE_W = 8;
  localparam int SPI_LEN_W  = 8;

  typedef enum logic [5:0] {
    ST_IDLE     = 6'b000001,
    ST_CS_SETUP = 6'b000010,
    ST_ISSUE    = 6'b000100,
    ST_WAIT_RX  = 6'b001000,
    ST_CS_HOLD  = 6'b010000,
    ST_DONE     = 6'b100000
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; head reads 0 when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/spi_burst_sequencer.sv
// Multi-byte SPI burst engine feeding spi_controller from a TX FIFO.
// Define SPI_SEQ_RX_CAPTURE_EN to capture received bytes into an RX FIFO.
module spi_burst_sequencer
  import spi_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CS_GUARD   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [SPI_BYTE_W-1:0] i_tx_data,
  input  logic                  i_tx_push,
  output logic                  o_tx_full,
  input  logic                  i_start,
  input  logic [SPI_LEN_W-1:0]  i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [SPI_BYTE_W-1:0] o_rx_data,
  output logic                  o_rx_valid,
  input  logic                  i_rx_pop,
  output logic                  o_rx_overflow,
  output logic [SPI_BYTE_W-1:0] o_ctrl_tx,
  output logic                  o_ctrl_tx_valid,
  input  logic                  i_ctrl_ready,
  input  logic [SPI_BYTE_W-1:0] i_ctrl_rx,
  input  logic                  i_ctrl_rx_valid,
  output logic                  o_cs_n
);

  localparam int GW = $clog2(CS_GUARD + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(CS_GUARD - 1);

  state_t                 state;
  logic [GW-1:0]          guard;
  logic [SPI_LEN_W-1:0]   remaining;
  logic [SPI_BYTE_W-1:0]  tx_head;
  logic                   tx_empty;
  logic                   tx_pop;
  logic                   accept;

  assign accept = (state == ST_IDLE) && i_start && (i_len != '0);
  assign tx_pop = (state == ST_ISSUE) && i_ctrl_ready && !tx_empty;

  sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_data (i_tx_data),
    .push    (i_tx_push),
    .pop     (tx_pop),
    .rd_data (tx_head),
    .full    (o_tx_full),
    .empty   (tx_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= ST_IDLE;
      guard           <= '0;
      remaining       <= '0;
      o_cs_n          <= 1'b1;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_ctrl_tx_valid <= 1'b0;
      o_ctrl_tx       <= '0;
    end else begin
      o_done          <= 1'b0;
      o_ctrl_tx_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            remaining <= i_len;
            guard     <= GUARD_LAST;
            o_cs_n    <= 1'b0;
            o_busy    <= 1'b1;
            state     <= ST_CS_SETUP;
          end
        end
        ST_CS_SETUP: begin
          if (guard == '0) state <= ST_ISSUE;
          else             guard <= guard - 1'b1;
        end
        ST_ISSUE: begin
          if (tx_pop) begin
            o_ctrl_tx_valid <= 1'b1;
            o_ctrl_tx       <= tx_head;
            state           <= ST_WAIT_RX;
          end
        end
        // Controller ready is deliberately not sampled while waiting for RX.
        ST_WAIT_RX: begin
          if (i_ctrl_rx_valid) begin
            if (remaining != '0) remaining <= remaining - 1'b1;
            if (remaining < SPI_LEN_W'(2)) begin
              guard <= GUARD_LAST;
              state <= ST_CS_HOLD;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_CS_HOLD: begin
          if (guard == '0) begin
            o_cs_n <= 1'b1;
            o_done <= 1'b1;
            state  <= ST_DONE;
          end else begin
            guard <= guard - 1'b1;
          end
        end
        ST_DONE: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_SEQ_RX_CAPTURE_EN
  logic rx_write;
  logic rx_full;
  logic rx_empty;
  logic overflow;

  assign rx_write = (state == ST_WAIT_RX) && i_ctrl_rx_valid;

  sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_data (i_ctrl_rx),
    .push    (rx_write),
    .pop     (i_rx_pop),
    .rd_data (o_rx_data),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst)                     overflow <= 1'b0;
    else if (accept)               overflow <= 1'b0;
    else if (rx_write && rx_full)  overflow <= 1'b1;
  end

  assign o_rx_valid    = !rx_empty;
  assign o_rx_overflow = overflow;
`else
  logic unused_rx;
  assign unused_rx     = ^{i_rx_pop, i_ctrl_rx};
  assign o_rx_valid    = 1'b0;
  assign o_rx_data     = '0;
  assign o_rx_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Directed bench for spi_burst_sequencer with a loopback controller model returning inverted bytes.
module tb_spi_burst_sequencer;

  localparam int G = 3;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_tx_data = '0;
  logic       i_tx_push = 1'b0;
  logic       o_tx_full;
  logic       i_start = 1'b0;
  logic [7:0] i_len = '0;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       i_rx_pop = 1'b0;
  logic       o_rx_overflow;
  logic [7:0] o_ctrl_tx;
  logic       o_ctrl_tx_valid;
  logic       i_ctrl_ready = 1'b1;
  logic [7:0] i_ctrl_rx = '0;
  logic       i_ctrl_rx_valid = 1'b0;
  logic       o_cs_n;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pulses = 0;
  int done_cnt = 0;
  int consec_bad = 0;
  int last_rx_cyc = 0;
  int rx_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0] held = '0;
  logic [7:0] tx_log [16];

`ifdef SPI_SEQ_RX_CAPTURE_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  spi_burst_sequencer #(.FIFO_DEPTH(D), .CS_GUARD(G)) dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_tx_data       (i_tx_data),
    .i_tx_push       (i_tx_push),
    .o_tx_full       (o_tx_full),
    .i_start         (i_start),
    .i_len           (i_len),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_rx_data       (o_rx_data),
    .o_rx_valid      (o_rx_valid),
    .i_rx_pop        (i_rx_pop),
    .o_rx_overflow   (o_rx_overflow),
    .o_ctrl_tx       (o_ctrl_tx),
    .o_ctrl_tx_valid (o_ctrl_tx_valid),
    .i_ctrl_ready    (i_ctrl_ready),
    .i_ctrl_rx       (i_ctrl_rx),
    .i_ctrl_rx_valid (i_ctrl_rx_valid),
    .o_cs_n          (o_cs_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Loopback controller: holds ready one cycle after accepting, returns ~byte 4 cycles later.
  always @(negedge clk) begin
    i_ctrl_rx_valid = 1'b0;
    if (o_ctrl_tx_valid && prev_valid) consec_bad++;
    prev_valid = o_ctrl_tx_valid;
    if (o_done) done_cnt++;
    if (i_rst) begin
      i_ctrl_ready = 1'b1;
      rx_cnt = 0;
    end else if (rx_cnt != 0) begin
      rx_cnt--;
      if (rx_cnt == 0) begin
        i_ctrl_rx       = ~held;
        i_ctrl_rx_valid = 1'b1;
        i_ctrl_ready    = 1'b1;
        last_rx_cyc     = cyc;
      end else begin
        i_ctrl_ready = 1'b0;
      end
    end else if (o_ctrl_tx_valid) begin
      held = o_ctrl_tx;
      tx_log[pulses % 16] = o_ctrl_tx;
      pulses++;
      rx_cnt = 4;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    i_tx_data = b;
    i_tx_push = 1'b1;
    tick;
    i_tx_push = 1'b0;
  endtask

  task automatic start(input logic [7:0] len);
    i_start = 1'b1;
    i_len   = len;
    tick;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    bit cs_bad = 1'b0;
    while (!o_done && n < 400) begin
      if (o_cs_n !== 1'b0) cs_bad = 1'b1;
      tick;
      n++;
    end
    chk({tag, "_done_seen"}, 32'(o_done), 1);
    chk({tag, "_cs_low_during"}, 32'(cs_bad), 0);
    chk({tag, "_cs_at_done"}, 32'(o_cs_n), 1);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
`ifdef SPI_SEQ_RX_CAPTURE_EN
    chk({tag, "_rx_valid"}, 32'(o_rx_valid), 1);
    chk({tag, "_rx_data"}, 32'(o_rx_data), 32'(exp));
`else
    chk({tag, "_rx_valid_tied"}, 32'(o_rx_valid), 0);
    chk({tag, "_rx_data_tied"}, 32'(o_rx_data), 0);
`endif
    i_rx_pop = 1'b1;
    tick;
    i_rx_pop = 1'b0;
  endtask

  task automatic wait_not_full;
    int n = 0;
    while (o_tx_full && n < 100) begin
      tick;
      n++;
    end
    chk("tx_space_wait", 32'(o_tx_full), 0);
  endtask

  initial begin
    int n;
    int d0;
    repeat (3) tick;
    i_rst = 1'b0;

    // Reset values
    chk("rst_cs_n", 32'(o_cs_n), 1);
    chk("rst_tx_full", 32'(o_tx_full), 0);
    chk("rst_rx_valid", 32'(o_rx_valid), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_ovf", 32'(o_rx_overflow), 0);
    chk("rst_ctrl_valid", 32'(o_ctrl_tx_valid), 0);
    chk("rst_ctrl_tx", 32'(o_ctrl_tx), 0);
    chk("rst_rx_data", 32'(o_rx_data), 0);

    // Two-byte loopback burst
    push(8'hA5);
    push(8'h3C);
    d0 = done_cnt;
    start(8'd2);
    chk("b1_cs_low_T1", 32'(o_cs_n), 0);
    chk("b1_busy_T1", 32'(o_busy), 1);
    wait_done("b1");
    chk("b1_done_timing", 32'(cyc), 32'(last_rx_cyc + 1 + G));
    chk("b1_busy_in_done", 32'(o_busy), 1);
    tick;
    chk("b1_done_fall", 32'(o_done), 0);
    chk("b1_busy_fall", 32'(o_busy), 0);
    chk("b1_done_once", 32'(done_cnt - d0), 1);
    chk("b1_pulses", 32'(pulses), 2);
    chk("b1_tx0", 32'(tx_log[0]), 32'h A5);
    chk("b1_tx1", 32'(tx_log[1]), 32'h 3C);
    pop_chk("b1_rx0", 8'h5A);
    pop_chk("b1_rx1", 8'hC3);
    chk("b1_rx_empty", 32'(o_rx_valid), 0);

    // Underflow stall: len 3 with one byte queued
    pulses = 0;
    push(8'h11);
    start(8'd3);
    repeat (30) tick;
    chk("b2_stall_cs", 32'(o_cs_n), 0);
    chk("b2_stall_busy", 32'(o_busy), 1);
    chk("b2_stall_pulses", 32'(pulses), 1);
    push(8'h22);
    push(8'h33);
    wait_done("b2");
    tick;
    chk("b2_pulses", 32'(pulses), 3);
    chk("b2_tx1", 32'(tx_log[1]), 32'h22);
    chk("b2_tx2", 32'(tx_log[2]), 32'h33);
    pop_chk("b2_rx0", 8'hEE);
    pop_chk("b2_rx1", 8'hDD);
    pop_chk("b2_rx2", 8'hCC);

    // Ignored starts: zero length, and start while busy
    pulses = 0;
    start(8'd0);
    repeat (5) tick;
    chk("b3_len0_cs", 32'(o_cs_n), 1);
    chk("b3_len0_busy", 32'(o_busy), 0);
    push(8'h44);
    start(8'd1);
    start(8'd5);
    chk("b3_busy_kept", 32'(o_busy), 1);
    chk("b3_cs_kept", 32'(o_cs_n), 0);
    wait_done("b3");
    repeat (10) tick;
    chk("b3_idle_cs", 32'(o_cs_n), 1);
    chk("b3_idle_busy", 32'(o_busy), 0);
    chk("b3_pulses", 32'(pulses), 1);
    pop_chk("b3_rx0", 8'hBB);

    // TX full: fifth push dropped
    pulses = 0;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    chk("b4_full", 32'(o_tx_full), 1);
    push(8'h55);
    start(8'd4);
    wait_done("b4");
    tick;
    chk("b4_pulses", 32'(pulses), 4);
    chk("b4_tx0", 32'(tx_log[0]), 32'h01);
    chk("b4_tx3", 32'(tx_log[3]), 32'h04);
    chk("b4_not_full", 32'(o_tx_full), 0);
    pop_chk("b4_rx0", 8'hFE);
    pop_chk("b4_rx1", 8'hFD);
    pop_chk("b4_rx2", 8'hFC);
    pop_chk("b4_rx3", 8'hFB);

    // RX overflow: six bytes into a depth-4 RX FIFO without popping
    pulses = 0;
    push(8'h10);
    push(8'h20);
    push(8'h30);
    push(8'h40);
    start(8'd6);
    wait_not_full;
    push(8'h50);
    wait_not_full;
    push(8'h60);
    wait_done("b5");
    tick;
    chk("b5_pulses", 32'(pulses), 6);
    chk("b5_tx4", 32'(tx_log[4]), 32'h50);
    chk("b5_tx5", 32'(tx_log[5]), 32'h60);
    chk("b5_ovf_set", 32'(o_rx_overflow), 32'(OVF_EXP));
    push(8'h70);
    start(8'd1);
    chk("b5_ovf_clear", 32'(o_rx_overflow), 0);
    wait_done("b5b");
    tick;
    pop_chk("b5_rx0", 8'hEF);
    pop_chk("b5_rx1", 8'hDF);
    pop_chk("b5_rx2", 8'hCF);
    pop_chk("b5_rx3", 8'hBF);
    chk("b5_rx_empty", 32'(o_rx_valid), 0);

    // Reset during WAIT_RX of byte 2 of 4
    pulses = 0;
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    push(8'hA4);
    start(8'd4);
    n = 0;
    while (pulses < 2 && n < 200) begin
      tick;
      n++;
    end
    chk("b6_reached_byte2", 32'(pulses), 2);
    i_rst = 1'b1;
    tick;
    i_rst = 1'b0;
    chk("b6_rst_cs", 32'(o_cs_n), 1);
    chk("b6_rst_busy", 32'(o_busy), 0);
    chk("b6_rst_tx_full", 32'(o_tx_full), 0);
    chk("b6_rst_rx_valid", 32'(o_rx_valid), 0);
    chk("b6_rst_ctrl_valid", 32'(o_ctrl_tx_valid), 0);
    tick;
    pulses = 0;
    push(8'hB1);
    push(8'hB2);
    start(8'd2);
    wait_done("b6");
    tick;
    chk("b6_pulses", 32'(pulses), 2);
    chk("b6_tx0", 32'(tx_log[0]), 32'hB1);
    chk("b6_tx1", 32'(tx_log[1]), 32'hB2);
    pop_chk("b6_rx0", 8'h4E);
    pop_chk("b6_rx1", 8'h4D);

    chk("ctrl_valid_single_cycle", 32'(consec_bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
